// File: rtl/config_chain_loader.sv
// Configuration scan-chain feeder: accepts host words over valid/ready, shifts them
// LSB-first onto prog_in/prog_en, then compares a trailing XOR check word.
//
// state      | meaning
// S_IDLE     | no load since reset; waiting for start
// S_WAIT_WORD| data_ready high, waiting for the next configuration word
// S_SHIFT    | driving one chain bit per cycle from the shift register
// S_WAIT_CHECK| data_ready high, waiting for the XOR check word
// S_DONE     | load finished; done/err held until start or reset
module config_chain_loader #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 24
) (
  input  logic                  prog_clk,
  input  logic                  prog_rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  prog_in,
  output logic                  prog_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NUM_WORDS = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_WIDTH;
  localparam int WCW       = $clog2(NUM_WORDS + 1);
  localparam int BCW       = $clog2(WORD_WIDTH + 1);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
  localparam logic [WCW-1:0] ALL_WORDS = WCW'(NUM_WORDS);
  localparam logic [BCW-1:0] FULL_CNT  = BCW'(WORD_WIDTH);
  localparam logic [BCW-1:0] LAST_CNT  = BCW'(LAST_BITS);
  localparam logic [BCW-1:0] ONE_CNT   = BCW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT,
    S_WAIT_CHECK,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  ready_q, ready_d;
  logic                  pin_q, pin_d;
  logic                  pen_q, pen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // bit_cnt_q holds the bits still to be presented, including the one on prog_in now
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    ready_d    = ready_q;
    pin_d      = 1'b0;
    pen_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d      = '0;
          word_cnt_d = '0;
          err_d      = 1'b0;
          done_d     = 1'b0;
          ready_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_WAIT_WORD;
        end
      end
      S_WAIT_WORD: begin
        if (data_valid && ready_q) begin
          shreg_d    = data_in >> 1;
          pin_d      = data_in[0];
          pen_d      = 1'b1;
          acc_d      = acc_q ^ data_in;
          bit_cnt_d  = (word_cnt_q == LAST_WORD) ? LAST_CNT : FULL_CNT;
          word_cnt_d = word_cnt_q + 1'b1;
          ready_d    = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == ONE_CNT) begin
          ready_d = 1'b1;
          state_d = (word_cnt_q == ALL_WORDS) ? S_WAIT_CHECK : S_WAIT_WORD;
        end else begin
          pin_d     = shreg_q[0];
          pen_d     = 1'b1;
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_WAIT_CHECK: begin
        if (data_valid && ready_q) begin
          err_d   = (data_in != acc_q);
          done_d  = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      acc_q      <= '0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      ready_q    <= 1'b0;
      pin_q      <= 1'b0;
      pen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      ready_q    <= ready_d;
      pin_q      <= pin_d;
      pen_q      <= pen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign data_ready = ready_q;
  assign prog_in    = pin_q;
  assign prog_en    = pen_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench: a 24-bit and a 20-bit loader, each feeding a modelled capture chain.
module tb_config_chain_loader;

  logic       prog_clk   = 1'b0;
  logic       prog_rst   = 1'b1;
  logic       start_a    = 1'b0;
  logic       start_b    = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in    = 8'h00;

  logic rdy_a, pin_a, pen_a, busy_a, done_a, err_a;
  logic rdy_b, pin_b, pen_b, busy_b, done_b, err_b;

  always #5 prog_clk = ~prog_clk;

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LEN(24)) u_a (
    .prog_clk(prog_clk), .prog_rst(prog_rst), .start(start_a), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy_a), .prog_in(pin_a), .prog_en(pen_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LEN(20)) u_b (
    .prog_clk(prog_clk), .prog_rst(prog_rst), .start(start_b), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy_b), .prog_in(pin_b), .prog_en(pen_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Downstream chain model: bits enter at the head and move toward prog_out (bit 0)
  int          cnt_a = 0, cnt_b = 0, bad_a = 0, bad_b = 0;
  logic [23:0] chain_a = '0;
  logic [19:0] chain_b = '0;
  logic        bits_a [0:1023];
  logic        bits_b [0:1023];

  always @(posedge prog_clk) begin
    if (pen_a) begin
      bits_a[cnt_a] <= pin_a;
      chain_a       <= {pin_a, chain_a[23:1]};
      cnt_a         <= cnt_a + 1;
    end
    if (pen_b) begin
      bits_b[cnt_b] <= pin_b;
      chain_b       <= {pin_b, chain_b[19:1]};
      cnt_b         <= cnt_b + 1;
    end
    if ((pen_a && rdy_a) || (!pen_a && pin_a)) bad_a <= bad_a + 1;
    if ((pen_b && rdy_b) || (!pen_b && pin_b)) bad_b <= bad_b + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int sel    = 0;
  int base   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic cur_ready();
    return (sel == 0) ? rdy_a : rdy_b;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cur_ready() && n < 200) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'(cur_ready()), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge prog_clk);
    if (sel == 0) start_a = 1'b1;
    else start_b = 1'b1;
    @(negedge prog_clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the handshake
  task automatic send_word(input logic [7:0] w, input int gap);
    int c0;
    int en_seen;
    if (gap > 0) begin
      wait_ready();
      c0 = cnt_a;
      en_seen = 0;
      repeat (gap) begin
        @(negedge prog_clk);
        if (pen_a) en_seen++;
      end
      chk("gap_shift_count", 32'(cnt_a - c0), 32'd0);
      chk("gap_prog_en", 32'(en_seen), 32'd0);
    end
    data_in    = w;
    data_valid = 1'b1;
    wait_ready();
    @(negedge prog_clk);
    data_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input logic [7:0] cw, input int gap);
    pulse_start();
    send_word(w0, 0);
    send_word(w1, gap);
    send_word(w2, gap);
    send_word(cw, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b8;
    logic [3:0] b4;
    int n;

    repeat (3) @(negedge prog_clk);
    chk("rst_ready", 32'(rdy_a), 32'd0);
    chk("rst_prog_en", 32'(pen_a), 32'd0);
    chk("rst_prog_in", 32'(pin_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    prog_rst = 1'b0;

    // nominal load
    base = cnt_a;
    run_load(8'hA5, 8'h3C, 8'h0F, 8'h96, 0);
    for (int i = 0; i < 8; i++) b8[i] = bits_a[base + i];
    chk("nom_shifts", 32'(cnt_a - base), 32'd24);
    chk("nom_first8", 32'(b8), 32'hA5);
    chk("nom_done", 32'(done_a), 32'd1);
    chk("nom_err", 32'(err_a), 32'd0);
    chk("nom_busy", 32'(busy_a), 32'd0);
    chk("nom_chain", 32'(chain_a), 32'h0F3CA5);

    // bad check word
    base = cnt_a;
    run_load(8'hA5, 8'h3C, 8'h0F, 8'h97, 0);
    chk("bad_shifts", 32'(cnt_a - base), 32'd24);
    chk("bad_done", 32'(done_a), 32'd1);
    chk("bad_err", 32'(err_a), 32'd1);

    // restart from DONE, start pulses while busy
    base = cnt_a;
    pulse_start();
    chk("restart_done", 32'(done_a), 32'd0);
    chk("restart_err", 32'(err_a), 32'd0);
    chk("restart_busy", 32'(busy_a), 32'd1);
    send_word(8'hA5, 0);
    pulse_start();
    send_word(8'h3C, 0);
    pulse_start();
    pulse_start();
    send_word(8'h0F, 0);
    send_word(8'h96, 0);
    chk("restart_shifts", 32'(cnt_a - base), 32'd24);
    chk("restart_final_done", 32'(done_a), 32'd1);
    chk("restart_final_err", 32'(err_a), 32'd0);
    chk("restart_chain", 32'(chain_a), 32'h0F3CA5);

    // back-pressure between words
    base = cnt_a;
    run_load(8'h5A, 8'hC3, 8'h81, 8'h18, 5);
    chk("bp_shifts", 32'(cnt_a - base), 32'd24);
    chk("bp_chain", 32'(chain_a), 32'h81C35A);
    chk("bp_done", 32'(done_a), 32'd1);
    chk("bp_err", 32'(err_a), 32'd0);

    // reset mid-load after 10 shifts
    base = cnt_a;
    pulse_start();
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    n = 0;
    while ((cnt_a - base) < 10 && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    chk("mid_reached_10", 32'(cnt_a - base), 32'd10);
    prog_rst = 1'b1;
    @(negedge prog_clk);
    chk("mid_prog_en", 32'(pen_a), 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_done", 32'(done_a), 32'd0);
    chk("mid_ready", 32'(rdy_a), 32'd0);
    prog_rst = 1'b0;
    base = cnt_a;
    run_load(8'hA5, 8'h3C, 8'h0F, 8'h96, 0);
    chk("reload_shifts", 32'(cnt_a - base), 32'd24);
    chk("reload_done", 32'(done_a), 32'd1);
    chk("reload_err", 32'(err_a), 32'd0);
    chk("reload_chain", 32'(chain_a), 32'h0F3CA5);

    // partial last word on the 20-bit chain
    sel  = 1;
    base = cnt_b;
    run_load(8'h00, 8'h00, 8'hF3, 8'hF3, 0);
    for (int i = 0; i < 4; i++) b4[i] = bits_b[base + 16 + i];
    chk("part_shifts", 32'(cnt_b - base), 32'd20);
    chk("part_last4", 32'(b4), 32'h3);
    chk("part_done", 32'(done_b), 32'd1);
    chk("part_err", 32'(err_b), 32'd0);
    chk("part_chain", 32'(chain_b), 32'h30000);

    chk("a_ready_or_in_outside_shift", 32'(bad_a), 32'd0);
    chk("b_ready_or_in_outside_shift", 32'(bad_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
